// File: rtl/adder_seq_ctrl.sv
// adder_seq_ctrl
//
// Instruction sequencer for the adder/accumulator datapath. It accepts one
// opcode plus an 8-bit immediate per valid/ready handshake. It then steps
// through a fixed microsequence that drives the datapath control word.
// Every control output except op_data comes straight from a register.
//
// Optional feature: define ADDER_SEQ_SKZ_EN to enable the SKZ
// (skip-if-zero) instruction. When it is undefined, opcode 101 decodes
// as NOP and the zf input is ignored.
//
// Ports
//   clk          in   clock, all state on the rising edge
//   rst          in   synchronous reset, active-high
//   instr_valid  in   instruction present on instr_op/instr_imm
//   instr_ready  out  sequencer can accept (transfer on valid & ready)
//   instr_op     in   3-bit opcode
//                     000 NOP, 001 LDA, 010 ADD, 011 SUB, 100 OUT,
//                     101 SKZ, 110 HLT, 111 NOP
//   instr_imm    in   8-bit immediate for LDA/ADD/SUB
//   zf           in   ALU zero flag from the datapath
//   op_data      out  operand byte to the datapath input buffer
//   ld_bus       out  datapath input buffer drives the bus
//   nla          out  load register A, active-low
//   nlb          out  load register B, active-low
//   ea           out  register A bus enable, held 0
//   eu           out  ALU drives the bus
//   sub          out  ALU subtract
//   out_sel      out  1 = output pins show the bus, 0 = show register A
//   out_strobe   out  one-cycle pulse, register A valid on the output pins
//   halted       out  HLT executed; cleared only by rst

module adder_seq_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [2:0] instr_op,
  input  logic [7:0] instr_imm,
  input  logic       zf,
  output logic [7:0] op_data,
  output logic       ld_bus,
  output logic       nla,
  output logic       nlb,
  output logic       ea,
  output logic       eu,
  output logic       sub,
  output logic       out_sel,
  output logic       out_strobe,
  output logic       halted
);

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LDA  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_OUT  = 3'b100;
  localparam logic [2:0] OP_SKZ  = 3'b101;
  localparam logic [2:0] OP_HLT  = 3'b110;
  localparam logic [2:0] OP_NOP2 = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_T3   = 3'd3,
    S_OUTS = 3'd4,
    S_HALT = 3'd5
  } state_t;

  state_t     state;
  logic [2:0] op_q;
  logic [7:0] imm_q;
  logic       ready_q;
  logic       accept;

`ifdef ADDER_SEQ_SKZ_EN
  logic       skip;
`else
  logic       unused_zf;
  assign unused_zf = zf;
`endif

  // Reset must drop ready within the same cycle, before the edge takes effect.
  assign instr_ready = ready_q & ~rst;
  assign accept      = instr_valid & instr_ready;
  assign ea          = 1'b0;

  // The datapath registers its input byte, so the immediate only needs to be
  // presented during T1; the bus sees it in T2.
  assign op_data = (state == S_T1) ? imm_q : 8'h00;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      op_q       <= OP_NOP;
      imm_q      <= 8'h00;
      ready_q    <= 1'b1;
      ld_bus     <= 1'b0;
      nla        <= 1'b1;
      nlb        <= 1'b1;
      eu         <= 1'b0;
      sub        <= 1'b0;
      out_sel    <= 1'b1;
      out_strobe <= 1'b0;
      halted     <= 1'b0;
`ifdef ADDER_SEQ_SKZ_EN
      skip       <= 1'b0;
`endif
    end else begin
      // Control word defaults; each state below only overrides what it drives.
      ld_bus     <= 1'b0;
      nla        <= 1'b1;
      nlb        <= 1'b1;
      eu         <= 1'b0;
      sub        <= 1'b0;
      out_sel    <= 1'b1;
      out_strobe <= 1'b0;

      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q  <= instr_op;
            imm_q <= instr_imm;
`ifdef ADDER_SEQ_SKZ_EN
            if (skip) begin
              // A pending skip consumes whatever arrives next, HLT included.
              skip <= 1'b0;
            end else begin
`else
            begin
`endif
              case (instr_op)
                OP_LDA, OP_ADD, OP_SUB: begin
                  state   <= S_T1;
                  ready_q <= 1'b0;
                  ld_bus  <= 1'b1;
                end
                OP_OUT: begin
                  state      <= S_OUTS;
                  ready_q    <= 1'b0;
                  out_sel    <= 1'b0;
                  out_strobe <= 1'b1;
                end
                OP_HLT: begin
                  state   <= S_HALT;
                  ready_q <= 1'b0;
                  halted  <= 1'b1;
                end
`ifdef ADDER_SEQ_SKZ_EN
                OP_SKZ: begin
                  // zf already reflects the previous instruction's result.
                  skip <= zf;
                end
`endif
                OP_NOP, OP_NOP2: begin
                end
                default: begin
                end
              endcase
            end
          end
        end

        // T1 -> T2: bus captures the primed byte into A (LDA) or B (ADD/SUB).
        S_T1: begin
          state  <= S_T2;
          ld_bus <= 1'b1;
          if (op_q == OP_LDA) begin
            nla <= 1'b0;
          end else begin
            nlb <= 1'b0;
          end
        end

        // T2 -> T3 or IDLE: LDA is complete; ADD/SUB write the ALU result into A.
        S_T2: begin
          if (op_q == OP_LDA) begin
            state   <= S_IDLE;
            ready_q <= 1'b1;
          end else begin
            state <= S_T3;
            eu    <= 1'b1;
            sub   <= (op_q == OP_SUB);
            nla   <= 1'b0;
          end
        end

        // T3 -> IDLE
        S_T3: begin
          state   <= S_IDLE;
          ready_q <= 1'b1;
        end

        // OUTS -> IDLE
        S_OUTS: begin
          state   <= S_IDLE;
          ready_q <= 1'b1;
        end

        S_HALT: begin
          halted  <= 1'b1;
          ready_q <= 1'b0;
        end

        default: begin
          state   <= S_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Testbench for adder_seq_ctrl. A transaction-level model turns each
// accepted instruction into the list of control words that must follow it.
// It also tracks register A with plain modulo-256 arithmetic, and that value
// drives zf. A single negedge process compares the DUT against the model.

module tb_adder_seq_ctrl;

`ifdef ADDER_SEQ_SKZ_EN
  localparam bit SKZ_EN = 1'b1;
`else
  localparam bit SKZ_EN = 1'b0;
`endif

  localparam logic [2:0] NOP = 3'b000, LDA = 3'b001, ADD = 3'b010, SUB = 3'b011,
                         OUT = 3'b100, SKZ = 3'b101, HLT = 3'b110;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       instr_valid = 1'b0;
  logic [2:0] instr_op = 3'b000;
  logic [7:0] instr_imm = 8'h00;
  logic       zf;
  logic       instr_ready;
  logic [7:0] op_data;
  logic       ld_bus, nla, nlb, ea, eu, sub, out_sel, out_strobe, halted;

  adder_seq_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr_op   (instr_op),
    .instr_imm  (instr_imm),
    .zf         (zf),
    .op_data    (op_data),
    .ld_bus     (ld_bus),
    .nla        (nla),
    .nlb        (nlb),
    .ea         (ea),
    .eu         (eu),
    .sub        (sub),
    .out_sel    (out_sel),
    .out_strobe (out_strobe),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       ready;
    logic       halted;
    logic       ld_bus;
    logic       nla;
    logic       nlb;
    logic       ea;
    logic       eu;
    logic       sub;
    logic       out_sel;
    logic       out_strobe;
    logic [7:0] op_data;
  } frame_t;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] acc = 8'h00;
  frame_t     exp_q[$];
  logic [7:0] outs[$];
  bit         m_skip = 1'b0;
  bit         m_halted = 1'b0;

  // The datapath's zero flag, taken from the model's register A.
  assign zf = (acc == 8'h00);

  function automatic frame_t idle_f();
    frame_t f;
    f = '0;
    f.ready   = 1'b1;
    f.nla     = 1'b1;
    f.nlb     = 1'b1;
    f.out_sel = 1'b1;
    return f;
  endfunction

  function automatic frame_t busy_f();
    frame_t f;
    f = idle_f();
    f.ready = 1'b0;
    return f;
  endfunction

  // Queue the control words that the instruction now on the bus must produce.
  task automatic model_accept();
    logic [2:0] op;
    logic [7:0] imm;
    frame_t     f;
    op  = instr_op;
    imm = instr_imm;
    if (m_skip) begin
      m_skip = 1'b0;
    end else begin
      case (op)
        LDA, ADD, SUB: begin
          f = busy_f(); f.ld_bus = 1'b1; f.op_data = imm; exp_q.push_back(f);
          f = busy_f(); f.ld_bus = 1'b1;
          if (op == LDA) f.nla = 1'b0; else f.nlb = 1'b0;
          exp_q.push_back(f);
          if (op == LDA) begin
            acc = imm;
          end else begin
            f = busy_f(); f.eu = 1'b1; f.sub = (op == SUB); f.nla = 1'b0;
            exp_q.push_back(f);
            acc = (op == SUB) ? acc - imm : acc + imm;
          end
        end
        OUT: begin
          f = busy_f(); f.out_sel = 1'b0; f.out_strobe = 1'b1;
          exp_q.push_back(f);
          outs.push_back(acc);
        end
        SKZ: if (SKZ_EN) m_skip = zf;
        HLT: m_halted = 1'b1;
        default: ;
      endcase
    end
  endtask

  always @(negedge clk) begin
    frame_t e, g;
    g = {instr_ready, halted, ld_bus, nla, nlb, ea, eu, sub, out_sel, out_strobe, op_data};
    vectors++;
    if (rst) begin
      if (instr_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL ready_in_reset t=%0t: got %b want 0", $time, instr_ready);
      end
      exp_q.delete();
      m_skip   = 1'b0;
      m_halted = 1'b0;
    end else begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
      end else if (m_halted) begin
        e = busy_f();
        e.halted = 1'b1;
      end else begin
        e = idle_f();
        if (instr_valid) model_accept();
      end
      if (g !== e) begin
        miscompares++;
        $display("FAIL ctrl_word t=%0t: got %h want %h", $time, g, e);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [2:0] op, input logic [7:0] imm);
    int n;
    n = 0;
    instr_valid = 1'b1;
    instr_op    = op;
    instr_imm   = imm;
    forever begin
      @(negedge clk);
      if (instr_ready) break;
      n++;
      if (n > 50) begin
        vectors++;
        miscompares++;
        $display("FAIL send_timeout: op %0d never accepted", op);
        break;
      end
    end
    @(posedge clk); #1;
    instr_valid = 1'b0;
    instr_op    = 3'b000;
    instr_imm   = 8'h00;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // LDA timing pinned by hand.
    send(LDA, 8'h25);
    @(negedge clk); check("lda_t1_bus_data", {23'd0, ld_bus, op_data}, {23'd0, 1'b1, 8'h25});
    @(negedge clk); check("lda_t2_nla", {31'd0, nla}, 32'd0);
    @(negedge clk); check("lda_ready_back", {31'd0, instr_ready}, 32'd1);
    @(posedge clk); #1;
    send(OUT, 8'h00);

    send(LDA, 8'hF0); send(ADD, 8'h20); send(OUT, 8'h00);

    send(LDA, 8'h05); send(SUB, 8'h05); send(SKZ, 8'h00);
    send(LDA, 8'h77); send(OUT, 8'h00);

    send(LDA, 8'h01); send(SKZ, 8'h00); send(LDA, 8'h33); send(OUT, 8'h00);

    repeat (4) @(posedge clk); #1;
    if (outs.size() < 4) begin
      vectors++;
      miscompares++;
      $display("FAIL out_count: got %0d want 4", outs.size());
    end else begin
      check("out_lda25",   {24'd0, outs[0]}, 32'h25);
      check("out_add_wrap", {24'd0, outs[1]}, 32'h10);
      check("out_skz_taken", {24'd0, outs[2]}, SKZ_EN ? 32'h00 : 32'h77);
      check("out_skz_not_taken", {24'd0, outs[3]}, 32'h33);
    end

    // HLT with a held instruction behind it.
    send(HLT, 8'h00);
    instr_valid = 1'b1; instr_op = LDA; instr_imm = 8'h55;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("halt_held", {30'd0, halted, instr_ready}, {30'd0, 2'b10});
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; instr_valid = 1'b0;
    @(negedge clk);
    check("halt_cleared", {30'd0, halted, instr_ready}, {30'd0, 2'b01});
    @(posedge clk); #1;

    // Reset in T2 of ADD.
    send(ADD, 8'h01);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mid_add", {27'd0, nla, nlb, eu, ld_bus, instr_ready}, {27'd0, 5'b11001});
    @(posedge clk); #1;

    repeat (3000) begin
      rst = ($urandom_range(0, 99) < 2) || (m_halted && $urandom_range(0, 7) == 0);
      instr_valid = ($urandom_range(0, 9) < 7);
      instr_op    = 3'($urandom);
      instr_imm   = 8'($urandom);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    instr_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
